cpu_run_ctrl: RTL and testbench

Run/halt/single-step sequencer for the single-cycle MIPS CPU. Sits between the board Go button, the control unit's syscall decode and the PC register, and produces the PC register's enable. Owns halt-on-syscall, resume-on-Go, single-step mode, an optional PC breakpoint and a saturating retired-instruction counter for the LED/count displays.

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/go_debounce.sv | 65 ++++++
 rtl/cpu_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - run/halt sequencer states, halt cause encodings and default halt code
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEPPING = 3'd2,
        ST_HALT     = 3'd3,
        ST_RESUME   = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_SYSCALL    = 2'b01,
        CAUSE_BREAKPOINT = 2'b10,
        CAUSE_STEP       = 2'b11
    } halt_cause_e;

    // $v0 value that turns a syscall into a halt (MIPS "exit")
    localparam logic [31:0] DEFAULT_HALT_CODE = 32'h0000_000A;

    // The board shows "halted" whenever the PC is frozen waiting for Go
    function automatic logic is_halted_state(input run_state_e s);
        return (s == ST_IDLE) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/go_debounce.sv
// rtl/go_debounce.sv - Go button synchronizer, debounce filter and one-cycle press pulse
module go_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic go_btn_i,
    output logic go_pulse_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= go_btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level, its previous value, and the registered rising-edge pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
        end
    end

    assign go_pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - PC enable sequencer: run, halt-on-syscall, single-step, optional breakpoint (BREAKPOINT_EN)
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] HALT_CODE       = DEFAULT_HALT_CODE,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go_btn,
    input  logic             step_mode,
    input  logic             syscall,
    input  logic [31:0]      sys_code,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             pc_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired_cnt
);

    run_state_e       state_q;
    run_state_e       state_d;
    halt_cause_e      cause_q;
    halt_cause_e      cause_d;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             go_pulse;
    logic             halt_req;
    logic             bp_hit;

    go_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk       (clk),
        .clr       (clr),
        .go_btn_i  (go_btn),
        .go_pulse_o(go_pulse)
    );

    assign halt_req = syscall && (sys_code == HALT_CODE);

`ifdef BREAKPOINT_EN
    logic skip_bp_q;
    logic skip_bp_d;

    assign bp_hit = bp_valid && (pc == bp_addr) && !skip_bp_q;

    // Suppress the breakpoint for the first RUN cycle so a resume can leave the breakpoint address
    always_comb begin
        skip_bp_d = skip_bp_q;
        if (state_q == ST_RUN) begin
            skip_bp_d = 1'b0;
        end
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            skip_bp_d = 1'b1;
        end
    end

    // Breakpoint skip flag register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            skip_bp_q <= 1'b0;
        end else begin
            skip_bp_q <= skip_bp_d;
        end
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_addr, bp_valid, pc};
`endif

    // State and latched halt cause
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next state; Go presses outside IDLE/HALT are dropped, a syscall halt outranks a breakpoint
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (go_pulse) begin
                    state_d = step_mode ? ST_STEPPING : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_SYSCALL;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BREAKPOINT;
                end
            end
            ST_STEPPING: begin
                state_d = ST_HALT;
                cause_d = halt_req ? CAUSE_SYSCALL : CAUSE_STEP;
            end
            ST_HALT: begin
                if (go_pulse) begin
                    state_d = step_mode ? ST_STEPPING : ST_RESUME;
                end
            end
            ST_RESUME: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC enable is combinational so a halting instruction is frozen in the very cycle it is at pc
    always_comb begin
        pc_en  = 1'b0;
        halted = is_halted_state(state_q);
        case (state_q)
            ST_RUN:      pc_en = !(halt_req || bp_hit);
            ST_STEPPING: pc_en = !halt_req;
            ST_RESUME:   pc_en = 1'b1;
            default:     pc_en = 1'b0;
        endcase
    end

    // Retired-instruction counter, sticks at all-ones
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            retired_cnt_q <= '0;
        end else if (pc_en && (retired_cnt_q != {CNT_W{1'b1}})) begin
            retired_cnt_q <= retired_cnt_q + 1'b1;
        end
    end

    assign halt_cause  = cause_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl with a behavioural PC register
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        go_btn;
    logic        step_mode;
    logic        syscall;
    logic [31:0] sys_code;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        pc_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] retired_cnt;

    logic        clr_s;
    logic        go_s;
    logic        pc_en_s;
    logic        halted_s;
    logic [1:0]  cause_s;
    logic [3:0]  cnt_s;

    logic        sc_armed;
    logic [31:0] sc_pc;
    logic        loop_en;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HALT_CODE      (32'h0000_000A),
        .CNT_W          (32)
    ) u_dut (
        .clk        (clk),
        .clr        (clr),
        .go_btn     (go_btn),
        .step_mode  (step_mode),
        .syscall    (syscall),
        .sys_code   (sys_code),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .pc_en      (pc_en),
        .halted     (halted),
        .halt_cause (halt_cause),
        .retired_cnt(retired_cnt)
    );

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HALT_CODE      (32'h0000_000A),
        .CNT_W          (4)
    ) u_sat (
        .clk        (clk),
        .clr        (clr_s),
        .go_btn     (go_s),
        .step_mode  (1'b0),
        .syscall    (1'b0),
        .sys_code   (32'h0),
        .pc         (32'h0),
        .bp_addr    (32'h0),
        .bp_valid   (1'b0),
        .pc_en      (pc_en_s),
        .halted     (halted_s),
        .halt_cause (cause_s),
        .retired_cnt(cnt_s)
    );

    // PC register model: +4 per enabled cycle, optional loop 0x28 -> 0x10
    always @(posedge clk or posedge clr) begin
        if (clr) pc <= 32'h0;
        else if (pc_en) pc <= (loop_en && pc == 32'h28) ? 32'h10 : pc + 32'h4;
    end

    // Control unit model: a syscall sits at one armed address
    always_comb syscall = sc_armed && (pc == sc_pc);

    task automatic press_go();
        go_btn = 1'b1;
        repeat (8) @(negedge clk);
        go_btn = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL rst_pc_en got=%b want=0", pc_en); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL rst_halted got=%b want=1", halted); end
        vectors++; if (halt_cause !== 2'b00) begin miscompares++; $display("FAIL rst_cause got=%b want=00", halt_cause); end
        vectors++; if (retired_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d want=0", retired_cnt); end
        clr = 1'b0;
        clr_s = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_go_debounce();
        int bad = 0;
        int first = 0;
        for (int i = 0; i < 10; i++) begin
            go_btn = ~go_btn;
            repeat (2) begin
                @(negedge clk);
                if (halted !== 1'b1) bad++;
            end
        end
        go_btn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (halted === 1'b0 && first == 0) first = n;
        end
        go_btn = 1'b0;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL bounce_no_go got=%0d want=0 non-halted cycles", bad); end
        vectors++; if (first != 8) begin miscompares++; $display("FAIL go_latency got=%0d want=8", first); end
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL go_run_pc got=%h want=00000010", pc); end
    endtask

    task automatic test_syscall_halt();
        sys_code = 32'd10;
        sc_pc = 32'h40;
        sc_armed = 1'b1;
        for (int i = 0; i < 40 && pc != 32'h40; i++) @(negedge clk);
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL sc_reach got=%h want=00000040", pc); end
        vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL sc_same_cycle got=%b want=0", pc_en); end
        @(negedge clk);
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL sc_halted got=%b want=1", halted); end
        vectors++; if (halt_cause !== 2'b01) begin miscompares++; $display("FAIL sc_cause got=%b want=01", halt_cause); end
        repeat (3) @(negedge clk);
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL sc_pc_hold got=%h want=00000040", pc); end
        press_go();
        vectors++; if (pc_en !== 1'b1 || pc !== 32'h40) begin miscompares++; $display("FAIL sc_resume got pc_en=%b pc=%h want pc_en=1 pc=00000040", pc_en, pc); end
        @(negedge clk);
        vectors++; if (pc !== 32'h44 || halted !== 1'b0) begin miscompares++; $display("FAIL sc_after_resume got pc=%h halted=%b want pc=00000044 halted=0", pc, halted); end
        sc_armed = 1'b0;
    endtask

    task automatic test_nonhalt_syscall();
        int bad = 0;
        logic [31:0] p0;
        p0 = pc;
        sys_code = 32'd34;
        sc_pc = p0 + 32'h8;
        sc_armed = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (pc_en !== 1'b1 || halted !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL code34_stall got=%0d want=0 stalled cycles", bad); end
        vectors++; if (pc !== p0 + 32'h10) begin miscompares++; $display("FAIL code34_pc got=%h want=%h", pc, p0 + 32'h10); end
        sc_armed = 1'b0;
    endtask

    task automatic test_clr_mid_run();
        for (int i = 0; i < 1000 && retired_cnt != 32'd500; i++) @(negedge clk);
        vectors++; if (retired_cnt !== 32'd500) begin miscompares++; $display("FAIL clr_pre_cnt got=%0d want=500", retired_cnt); end
        clr = 1'b1;
        #1;
        vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL clr_pc_en got=%b want=0", pc_en); end
        vectors++; if (retired_cnt !== 32'd0) begin miscompares++; $display("FAIL clr_cnt got=%0d want=0", retired_cnt); end
        vectors++; if (halted !== 1'b1 || halt_cause !== 2'b00) begin miscompares++; $display("FAIL clr_state got halted=%b cause=%b want halted=1 cause=00", halted, halt_cause); end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_single_step();
        step_mode = 1'b1;
        repeat (8) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            press_go();
            vectors++; if (pc_en !== 1'b1 || pc !== 32'(4 * s)) begin miscompares++; $display("FAIL step%0d_en got pc_en=%b pc=%h want pc_en=1 pc=%h", s, pc_en, pc, 32'(4 * s)); end
            @(negedge clk);
            vectors++; if (halted !== 1'b1 || halt_cause !== 2'b11 || pc !== 32'(4 * s + 4)) begin miscompares++; $display("FAIL step%0d_halt got halted=%b cause=%b pc=%h want 1 11 %h", s, halted, halt_cause, pc, 32'(4 * s + 4)); end
            repeat (8) @(negedge clk);
        end
        vectors++; if (retired_cnt !== 32'd3) begin miscompares++; $display("FAIL step_cnt got=%0d want=3", retired_cnt); end
        sys_code = 32'd10;
        sc_pc = 32'hC;
        sc_armed = 1'b1;
        press_go();
        vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL step_sc_en got=%b want=0", pc_en); end
        @(negedge clk);
        vectors++; if (halt_cause !== 2'b01 || pc !== 32'hC || retired_cnt !== 32'd3) begin miscompares++; $display("FAIL step_sc_halt got cause=%b pc=%h cnt=%0d want 01 0000000c 3", halt_cause, pc, retired_cnt); end
        repeat (8) @(negedge clk);
        sc_armed = 1'b0;
        step_mode = 1'b0;
        press_go();
        vectors++; if (pc_en !== 1'b1 || pc !== 32'hC) begin miscompares++; $display("FAIL step_resume got pc_en=%b pc=%h want 1 0000000c", pc_en, pc); end
        @(negedge clk);
        vectors++; if (pc !== 32'h10 || halted !== 1'b0 || retired_cnt !== 32'd4) begin miscompares++; $display("FAIL step_to_run got pc=%h halted=%b cnt=%0d want 00000010 0 4", pc, halted, retired_cnt); end
    endtask

    task automatic test_breakpoint();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bp_addr = 32'h20;
        bp_valid = 1'b1;
        step_mode = 1'b0;
`ifdef BREAKPOINT_EN
        loop_en = 1'b1;
        press_go();
        for (int i = 0; i < 40 && halted !== 1'b1; i++) @(negedge clk);
        vectors++; if (halted !== 1'b1 || pc !== 32'h20 || halt_cause !== 2'b10) begin miscompares++; $display("FAIL bp_hit1 got halted=%b pc=%h cause=%b want 1 00000020 10", halted, pc, halt_cause); end
        repeat (8) @(negedge clk);
        press_go();
        vectors++; if (pc_en !== 1'b1 || pc !== 32'h20) begin miscompares++; $display("FAIL bp_resume got pc_en=%b pc=%h want 1 00000020", pc_en, pc); end
        @(negedge clk);
        vectors++; if (pc !== 32'h24 || halted !== 1'b0) begin miscompares++; $display("FAIL bp_step_past got pc=%h halted=%b want 00000024 0", pc, halted); end
        for (int i = 0; i < 40 && halted !== 1'b1; i++) @(negedge clk);
        vectors++; if (halted !== 1'b1 || pc !== 32'h20 || halt_cause !== 2'b10) begin miscompares++; $display("FAIL bp_hit2 got halted=%b pc=%h cause=%b want 1 00000020 10", halted, pc, halt_cause); end
`else
        press_go();
        repeat (12) @(negedge clk);
        vectors++; if (halted !== 1'b0 || pc !== 32'h30 || pc_en !== 1'b1) begin miscompares++; $display("FAIL bp_disabled got halted=%b pc=%h pc_en=%b want 0 00000030 1", halted, pc, pc_en); end
`endif
        loop_en = 1'b0;
        bp_valid = 1'b0;
    endtask

    task automatic test_saturation();
        go_s = 1'b1;
        repeat (8) @(negedge clk);
        go_s = 1'b0;
        vectors++; if (pc_en_s !== 1'b1 || halted_s !== 1'b0 || cnt_s !== 4'd0) begin miscompares++; $display("FAIL sat_start got pc_en=%b halted=%b cnt=%0d want 1 0 0", pc_en_s, halted_s, cnt_s); end
        repeat (10) @(negedge clk);
        vectors++; if (cnt_s !== 4'd10) begin miscompares++; $display("FAIL sat_mid got=%0d want=10", cnt_s); end
        repeat (10) @(negedge clk);
        vectors++; if (cnt_s !== 4'd15 || pc_en_s !== 1'b1) begin miscompares++; $display("FAIL sat_hold got cnt=%0d pc_en=%b want 15 1", cnt_s, pc_en_s); end
        vectors++; if (cause_s !== 2'b00) begin miscompares++; $display("FAIL sat_cause got=%b want=00", cause_s); end
    endtask

    initial begin
        clr = 1'b1;
        clr_s = 1'b1;
        go_btn = 1'b0;
        go_s = 1'b0;
        step_mode = 1'b0;
        sys_code = 32'h0;
        bp_addr = 32'h0;
        bp_valid = 1'b0;
        sc_armed = 1'b0;
        sc_pc = 32'h0;
        loop_en = 1'b0;
        test_reset();
        test_go_debounce();
        test_syscall_halt();
        test_nonhalt_syscall();
        test_clr_mid_run();
        test_single_step();
        test_breakpoint();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
